// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detection and WOS multi-cycle scoreboard.
// Stalls decode and bubbles EX on load-use, RAW/WAW against in-flight WOS results, and WOS busy.
module hazard_scoreboard #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_issue_valid_d,
  input  logic        i_flush_d,
  input  logic [4:0]  i_rs1_d,
  input  logic [4:0]  i_rs2_d,
  input  logic        i_rs1_used_d,
  input  logic        i_rs2_used_d,
  input  logic [4:0]  i_rd_d,
  input  logic        i_w_en_d,
  input  logic        i_is_mc_d,
  input  logic [4:0]  i_rd_e,
  input  logic        i_w_en_e,
  input  logic        i_is_load_e,
  input  logic        i_mc_done,
  output logic        o_stall_d,
  output logic        o_bubble_e,
  output logic [31:0] o_pending,
  output logic        o_mc_busy,
  output logic        o_mc_timeout,
  output logic        o_proto_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0]      pending_q, pending_d;
  logic             busy_q, busy_d;
  logic [4:0]       mc_rd_q, mc_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;

  logic haz_lu, haz_raw, haz_waw, haz_struct;
  logic hazard, accept;

  always_comb begin
    haz_lu = i_is_load_e & i_w_en_e & (i_rd_e != 5'd0) &
             ((i_rs1_used_d & (i_rs1_d == i_rd_e)) |
              (i_rs2_used_d & (i_rs2_d == i_rd_e)));
    haz_raw    = (i_rs1_used_d & pending_q[i_rs1_d]) |
                 (i_rs2_used_d & pending_q[i_rs2_d]);
    haz_waw    = i_w_en_d & pending_q[i_rd_d];
    haz_struct = i_is_mc_d & busy_q;
    hazard     = i_issue_valid_d & ~i_flush_d &
                 (haz_lu | haz_raw | haz_waw | haz_struct);
    accept     = i_issue_valid_d & ~i_flush_d & ~hazard;
  end

  assign o_stall_d    = i_rst_n & hazard;
  assign o_bubble_e   = i_rst_n & hazard;
  assign o_pending    = pending_q;
  assign o_mc_busy    = busy_q;
  assign o_mc_timeout = timeout_q;
  assign o_proto_err  = proto_err_q;

  // An mc accept can never coincide with a completing op: struct stalls on busy_q.
  always_comb begin
    pending_d   = pending_q;
    busy_d      = busy_q;
    mc_rd_d     = mc_rd_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;

    if (i_mc_done) begin
      if (busy_q) begin
        busy_d             = 1'b0;
        pending_d[mc_rd_q] = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end else if (busy_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (cnt_q == CNT_TRIP) begin
        timeout_d = 1'b1;
      end
    end

    if (accept & i_is_mc_d) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mc_rd_d = i_w_en_d ? i_rd_d : 5'd0;
      if (i_w_en_d & (i_rd_d != 5'd0)) begin
        pending_d[i_rd_d] = 1'b1;
      end
    end

    pending_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q   <= '0;
      busy_q      <= 1'b0;
      mc_rd_q     <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      mc_rd_q     <= mc_rd_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a cycle-level model of the scoreboard rules.
module tb_hazard_scoreboard;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, flush;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, w_en, is_mc;
  logic [4:0]  rd_e;
  logic        w_en_e, is_load_e, mc_done;
  logic        o_stall_d, o_bubble_e, o_mc_busy, o_mc_timeout, o_proto_err;
  logic [31:0] o_pending;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  bit [31:0] m_pend;
  bit        m_busy, m_to, m_pe;
  bit [4:0]  m_rd;
  int        m_cyc, m_issue;

  always #5 clk = ~clk;

  hazard_scoreboard #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_issue_valid_d(issue_valid), .i_flush_d(flush),
    .i_rs1_d(rs1), .i_rs2_d(rs2), .i_rs1_used_d(rs1_used), .i_rs2_used_d(rs2_used),
    .i_rd_d(rd), .i_w_en_d(w_en), .i_is_mc_d(is_mc),
    .i_rd_e(rd_e), .i_w_en_e(w_en_e), .i_is_load_e(is_load_e),
    .i_mc_done(mc_done),
    .o_stall_d(o_stall_d), .o_bubble_e(o_bubble_e), .o_pending(o_pending),
    .o_mc_busy(o_mc_busy), .o_mc_timeout(o_mc_timeout), .o_proto_err(o_proto_err)
  );

  function automatic logic f_hazard();
    logic lu, raw, waw, st;
    lu  = is_load_e && w_en_e && (rd_e != 0) &&
          ((rs1_used && rs1 == rd_e) || (rs2_used && rs2 == rd_e));
    raw = (rs1_used && m_pend[rs1]) || (rs2_used && m_pend[rs2]);
    waw = w_en && m_pend[rd];
    st  = is_mc && m_busy;
    return rst_n && issue_valid && !flush && (lu || raw || waw || st);
  endfunction

  // Advance the model by one cycle using the current inputs, then clock the DUT.
  task automatic tick();
    logic acc;
    acc = rst_n && issue_valid && !flush && !f_hazard();
    if (!rst_n) begin
      m_pend = '0; m_busy = 0; m_to = 0; m_pe = 0; m_rd = '0;
    end else begin
      if (mc_done) begin
        if (m_busy) begin
          m_busy = 0;
          m_pend[m_rd] = 0;
        end else begin
          m_pe = 1;
        end
      end else if (m_busy && (m_cyc - m_issue) >= TIMEOUT) begin
        m_to = 1;
      end
      if (acc && is_mc) begin
        m_busy  = 1;
        m_issue = m_cyc;
        m_rd    = w_en ? rd : 5'd0;
        if (w_en && rd != 0) m_pend[rd] = 1;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; flush = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    rd = 0; w_en = 0; is_mc = 0; rd_e = 0; w_en_e = 0; is_load_e = 0; mc_done = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic set_decode(input logic [4:0] a, input logic ua, input logic [4:0] b,
                            input logic ub, input logic [4:0] d, input logic we,
                            input logic mc);
    issue_valid = 1; flush = 0;
    rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub; rd = d; w_en = we; is_mc = mc;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    set_decode(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    is_load_e = 1; w_en_e = 1; rd_e = 5'd5;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0 || o_bubble_e !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b/%b want 0/0", o_stall_d, o_bubble_e);
    end
    tick();
    n_checks++;
    if ({o_pending, o_mc_busy, o_mc_timeout, o_proto_err} !== 35'd0) begin
      n_err++; $display("FAIL reset_state: got %h %b%b%b want 0", o_pending, o_mc_busy,
                        o_mc_timeout, o_proto_err);
    end
    idle();
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    int stalls;
    do_reset();
    set_decode(5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
    is_load_e = 1; w_en_e = 1; rd_e = 5'd5;
    stalls = 0;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b1 || o_bubble_e !== 1'b1) begin
      n_err++; $display("FAIL lu_stall: got %b/%b want 1/1", o_stall_d, o_bubble_e);
    end
    for (int k = 0; k < 3; k++) begin
      if (o_stall_d === 1'b1) stalls++;
      tick();
      is_load_e = 0; w_en_e = 0; rd_e = 0;
      #1;
    end
    n_checks++;
    if (stalls != 1) begin
      n_err++; $display("FAIL lu_len: got %0d stall cycles want 1", stalls);
    end
    set_decode(5'd0, 1, 5'd1, 1, 5'd6, 1, 0);
    is_load_e = 1; w_en_e = 1; rd_e = 5'd0;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0) begin
      n_err++; $display("FAIL lu_x0: got %b want 0", o_stall_d);
    end
    rd_e = 5'd1;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b1) begin
      n_err++; $display("FAIL lu_rs2: got %b want 1", o_stall_d);
    end
    rs2_used = 0;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0) begin
      n_err++; $display("FAIL lu_unused: got %b want 0", o_stall_d);
    end
    tick();
    idle();
  endtask

  task automatic test_raw_wos();
    do_reset();
    set_decode(5'd1, 1, 5'd2, 1, 5'd7, 1, 1);
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0) begin
      n_err++; $display("FAIL raw_issue: got %b want 0", o_stall_d);
    end
    tick();
    set_decode(5'd7, 1, 5'd3, 1, 5'd10, 1, 0);
    for (int k = 0; k < 9; k++) begin
      #1;
      n_checks++;
      if (o_stall_d !== 1'b1 || o_pending[7] !== 1'b1) begin
        n_err++; $display("FAIL raw_wait%0d: got stall %b pend %b want 1 1", k, o_stall_d,
                          o_pending[7]);
      end
      tick();
    end
    mc_done = 1;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b1 || o_pending[7] !== 1'b1) begin
      n_err++; $display("FAIL raw_done_cycle: got stall %b pend %b want 1 1", o_stall_d,
                        o_pending[7]);
    end
    tick();
    mc_done = 0;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0 || o_pending !== 32'd0 || o_mc_busy !== 1'b0) begin
      n_err++; $display("FAIL raw_release: got stall %b pend %h busy %b want 0 0 0", o_stall_d,
                        o_pending, o_mc_busy);
    end
    tick();
    idle();
  endtask

  task automatic test_struct_waw();
    do_reset();
    set_decode(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    set_decode(5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    #1;
    n_checks++;
    if (o_stall_d !== 1'b1) begin
      n_err++; $display("FAIL struct: got %b want 1", o_stall_d);
    end
    tick();
    set_decode(5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
    #1;
    n_checks++;
    if (o_stall_d !== 1'b1) begin
      n_err++; $display("FAIL waw: got %b want 1", o_stall_d);
    end
    tick();
    set_decode(5'd1, 1, 5'd2, 1, 5'd8, 1, 0);
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0) begin
      n_err++; $display("FAIL indep: got %b want 0", o_stall_d);
    end
    tick();
    n_checks++;
    if (o_pending !== 32'h0000_0080) begin
      n_err++; $display("FAIL indep_pend: got %h want %h", o_pending, 32'h80);
    end
    idle();
    mc_done = 1;
    tick();
    mc_done = 0;
  endtask

  task automatic test_x0_flush();
    do_reset();
    set_decode(5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    tick();
    idle();
    #1;
    n_checks++;
    if (o_mc_busy !== 1'b1 || o_pending !== 32'd0) begin
      n_err++; $display("FAIL x0_mc: got busy %b pend %h want 1 0", o_mc_busy, o_pending);
    end
    set_decode(5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    flush = 1;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: got %b want 0", o_stall_d);
    end
    tick();
    n_checks++;
    if (o_mc_busy !== 1'b1 || o_pending !== 32'd0) begin
      n_err++; $display("FAIL flush_state: got busy %b pend %h want 1 0", o_mc_busy, o_pending);
    end
    idle();
    mc_done = 1;
    tick();
    mc_done = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    set_decode(5'd0, 0, 5'd0, 0, 5'd3, 1, 1);
    tick();
    idle();
    for (int k = 1; k <= TIMEOUT; k++) begin
      #1;
      n_checks++;
      if (o_mc_timeout !== 1'b0) begin
        n_err++; $display("FAIL to_early%0d: got %b want 0", k, o_mc_timeout);
      end
      tick();
    end
    n_checks++;
    if (o_mc_timeout !== 1'b1 || o_mc_busy !== 1'b1) begin
      n_err++; $display("FAIL to_set: got to %b busy %b want 1 1", o_mc_timeout, o_mc_busy);
    end
    mc_done = 1;
    tick();
    n_checks++;
    if (o_mc_timeout !== 1'b1 || o_mc_busy !== 1'b0 || o_pending !== 32'd0) begin
      n_err++; $display("FAIL to_sticky: got to %b busy %b pend %h want 1 0 0", o_mc_timeout,
                        o_mc_busy, o_pending);
    end
    tick();
    mc_done = 0;
    n_checks++;
    if (o_proto_err !== 1'b1 || o_pending !== 32'd0) begin
      n_err++; $display("FAIL proto: got pe %b pend %h want 1 0", o_proto_err, o_pending);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_decode(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick();
    set_decode(5'd4, 1, 5'd0, 0, 5'd5, 1, 1);
    rst_n = 0;
    #1;
    n_checks++;
    if (o_stall_d !== 1'b0 || o_bubble_e !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_stall: got %b/%b want 0/0", o_stall_d, o_bubble_e);
    end
    tick();
    n_checks++;
    if ({o_pending, o_mc_busy, o_mc_timeout, o_proto_err, o_stall_d} !== 36'd0) begin
      n_err++; $display("FAIL rst_mid_state: got %h %b%b%b%b want 0", o_pending, o_mc_busy,
                        o_mc_timeout, o_proto_err, o_stall_d);
    end
    rst_n = 1;
    idle();
    mc_done = 1;
    tick();
    mc_done = 0;
    n_checks++;
    if (o_proto_err !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_proto: got %b want 1", o_proto_err);
    end
  endtask

  task automatic test_random();
    logic exp_st;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      issue_valid = ($urandom_range(0, 9) < 8);
      flush       = ($urandom_range(0, 9) == 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7)); rd_e = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom); rs2_used = 1'($urandom); w_en = 1'($urandom);
      is_mc     = ($urandom_range(0, 9) < 3);
      w_en_e    = 1'($urandom);
      is_load_e = ($urandom_range(0, 9) < 4);
      mc_done   = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      #1;
      exp_st = f_hazard();
      n_checks++;
      if (o_stall_d !== exp_st || o_bubble_e !== exp_st) begin
        n_err++; $display("FAIL rnd_stall@%0d: got %b/%b want %b", k, o_stall_d, o_bubble_e,
                          exp_st);
      end
      n_checks++;
      if (o_pending !== m_pend || o_mc_busy !== m_busy) begin
        n_err++; $display("FAIL rnd_state@%0d: got pend %h busy %b want %h %b", k, o_pending,
                          o_mc_busy, m_pend, m_busy);
      end
      n_checks++;
      if (o_mc_timeout !== m_to || o_proto_err !== m_pe) begin
        n_err++; $display("FAIL rnd_flags@%0d: got to %b pe %b want %b %b", k, o_mc_timeout,
                          o_proto_err, m_to, m_pe);
      end
      tick();
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    m_pend = '0; m_busy = 0; m_to = 0; m_pe = 0; m_rd = '0; m_cyc = 0; m_issue = 0;
    rst_n = 0;
    idle();
    test_reset();
    test_load_use();
    test_raw_wos();
    test_struct_waw();
    test_x0_flush();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Decode-stage hazard and issue-control block for the 5-stage core. It tracks register writes still in flight from the multi-cycle WOS filter unit and detects load-use hazards, then stalls decode and injects EX bubbles until operands can be obtained. It is the producer-side counterpart to EX-stage operand forwarding: forwarding selects results that already exist, and this block holds back instructions whose results do not exist yet. It sits between the ID/EX pipeline register control and the WOS coprocessor.

## Interface
- TIMEOUT, 64: cycles a multi-cycle op may stay outstanding before the timeout flag sets; must be ≥ 2.
- CNT_W, $clog2(TIMEOUT+1): width of the outstanding-cycle counter.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_issue_valid_d  in  1  a valid instruction is in decode.
- i_flush_d  in  1  the decode instruction is killed this cycle.
- i_rs1_d, i_rs2_d  in  5 each  decode source register indices.
- i_rs1_used_d, i_rs2_used_d  in  1 each  the source is actually read.
- i_rd_d  in  5  decode destination register index.
- i_w_en_d  in  1  decode instruction writes rd.
- i_is_mc_d  in  1  decode instruction is a multi-cycle WOS op.
- i_rd_e  in  5  EX destination register index.
- i_w_en_e  in  1  EX instruction writes rd.
- i_is_load_e  in  1  EX instruction is a load.
- i_mc_done  in  1  the WOS unit writes its result back this cycle (single-cycle pulse).
- o_stall_d  out  1  hold PC and IF/ID; do not accept the decode instruction.
- o_bubble_e  out  1  load a NOP into ID/EX.
- o_pending  out  32  scoreboard; bit r means register r awaits a WOS result.
- o_mc_busy  out  1  a WOS op is outstanding.
- o_mc_timeout  out  1  sticky: an outstanding op exceeded TIMEOUT cycles.
- o_proto_err  out  1  sticky: i_mc_done arrived while not busy.

## Operation
- **State:** pending[31:0], busy, mc_rd[4:0], cnt[CNT_W-1:0], and the two sticky flags.
- **Reset:** while i_rst_n is low, every register clears to 0 at the edge. o_stall_d and o_bubble_e are forced to 0 while i_rst_n is low.
- **x0 handling:** register x0 is never pending and never creates a hazard.
- **Hazard terms.** All are computed combinationally from *registered* state and the current inputs:
  - lu (load-use): i_is_load_e & i_w_en_e & i_rd_e≠0 & ((i_rs1_used_d & i_rs1_d==i_rd_e) | (i_rs2_used_d & i_rs2_d==i_rd_e)).
  - raw: (i_rs1_used_d & pending[i_rs1_d]) | (i_rs2_used_d & pending[i_rs2_d]).
  - waw: i_w_en_d & pending[i_rd_d].
  - struct: i_is_mc_d & busy.
- **Stall and bubble:** o_stall_d = o_bubble_e = i_issue_valid_d & ~i_flush_d & (lu|raw|waw|struct).
- **Accept:** acc = i_issue_valid_d & ~i_flush_d & ~o_stall_d.
- **On acc & i_is_mc_d:**
  - busy←1, cnt←0, mc_rd←(i_w_en_d ? i_rd_d : 0).
  - If i_w_en_d & i_rd_d≠0, pending[i_rd_d]←1.
- **On i_mc_done & busy:** busy←0 and pending[mc_rd]←0.
- **On i_mc_done & ~busy:** no state change except o_proto_err←1.
- **Done and accepted issue in the same cycle:**
  - Cannot happen for an mc op, because struct stalls on the registered busy.
  - A non-mc accept alongside done is independent of it.
- **Counter:**
  - While busy & ~i_mc_done, cnt increments and saturates at TIMEOUT.
  - When cnt==TIMEOUT-1 and the op is not done, o_mc_timeout←1. It stays set until reset.
  - busy is not cleared by a timeout.
- **Flush:** i_flush_d never clears pending/busy, because an already-issued WOS op still completes.

## Timing
- Hazard outputs are combinational and have zero-cycle latency.
- An mc op accepted in cycle N has busy/pending visible in N+1, so a dependent instruction stalls from N+1.
- i_mc_done in cycle M clears state at the M edge. A dependent instruction stalls in M and issues in M+1.
- A load-use stall lasts exactly one cycle: the load moves to MEM and forwarding covers the operand.
- o_mc_timeout rises after the edge closing cycle N+TIMEOUT, where N is the issue cycle.
- Reset asserted mid-operation discards the outstanding op. A later i_mc_done for that op sets o_proto_err.

## Test plan
- **Load-use:** lw x5 in EX; decode add x6,x5,x1 (rs1 used) -> o_stall_d=o_bubble_e=1 for exactly 1 cycle, then issue. The same case with rd_e=0 -> no stall.
- **RAW on WOS:** issue mc op rd=x7 in cycle 10; decode reads x7 from cycle 11 -> stall until i_mc_done in cycle 20; issue in cycle 21; o_pending[7] is 1 over cycles 11–20 and 0 at 21.
- **Structural/WAW:** while busy, a second mc op (any rd) stalls. A non-mc op with rd=x7 stalls while x7 is pending. A non-mc op with rd=x8 and sources ≠x7 issues with no stall.
- **rd=x0 / flush:** mc op with rd=0 -> busy=1, o_pending=0. Flush asserted on a stalled mc op -> no stall and no state change.
- **Timeout/protocol:** TIMEOUT=4, no done -> o_mc_timeout=1 after 4 busy cycles and stays set after a later done. i_mc_done with busy=0 -> o_proto_err=1 and o_pending unchanged.
- **Reset:** i_rst_n low mid-op -> all outputs 0 the next cycle, including o_stall_d while reset is held.
